// File: rtl/vga_pkg.sv
// Shared screen geometry for the menu buttons, plus the click-conditioning
// types used by the mouse path.
package vga_pkg;

    localparam logic [11:0] RECT_X_MIDDLE = 12'd400;
    localparam logic [11:0] RECT_CHAR_X   = 12'd224;
    localparam logic [11:0] RECT_Y        = 12'd200;
    localparam logic [11:0] RECT_Y_2      = 12'd320;
    localparam logic [11:0] RECT_CHAR_Y   = 12'd64;

    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_TOP    = 2'd1,
        REG_BOTTOM = 2'd2
    } click_region_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounce_state_t;

    // Inclusive range test; the upper bound is formed one bit wider so lo+span never wraps.
    function automatic logic in_span(logic [11:0] v, logic [11:0] lo, logic [11:0] span);
        logic [12:0] hi;
        hi = {1'b0, lo} + {1'b0, span};
        return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} <= hi);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus debounce FSM for one mouse button; produces the
// clean held level and single-cycle press/release pulses.
module button_debouncer
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic held_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            sync1_q, sync2_q;
    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            held_q, held_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The limit check precedes the increment, so cnt_q tops out at CNT_MAX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    held_d  = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    held_d    = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    assign held_o       = held_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/mouse_click_conditioner.sv
// Conditions raw mouse buttons for the game FSM: debounced levels and pulses,
// and the cursor position / menu hit region latched on each left press.
module mouse_click_conditioner
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left_raw,
    input  logic        mouse_right_raw,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic        left_held,
    output logic        right_held,
    output logic        left_press,
    output logic        left_release,
    output logic        right_press,
    output logic        right_release,
    output logic [11:0] click_x,
    output logic [11:0] click_y,
    output logic [1:0]  click_region
);

    logic          left_press_next;
    logic          right_press_next_unused;
    logic [11:0]   click_x_q, click_y_q;
    click_region_t region_q, region_d;
    logic          x_in, top_in, bot_in;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_left (
        .clk         (clk),
        .rst         (rst),
        .raw_i       (mouse_left_raw),
        .held_o      (left_held),
        .press_o     (left_press),
        .release_o   (left_release),
        .press_next_o(left_press_next)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_right (
        .clk         (clk),
        .rst         (rst),
        .raw_i       (mouse_right_raw),
        .held_o      (right_held),
        .press_o     (right_press),
        .release_o   (right_release),
        .press_next_o(right_press_next_unused)
    );

    // Hit test runs on the position seen in the cycle the press is decided.
    always_comb begin
        x_in   = in_span(xpos, RECT_X_MIDDLE, RECT_CHAR_X);
        top_in = x_in && in_span(ypos, RECT_Y, RECT_CHAR_Y);
        bot_in = x_in && in_span(ypos, RECT_Y_2, RECT_CHAR_Y);
        region_d = REG_NONE;
        if (top_in) begin
            region_d = REG_TOP;
        end else if (bot_in) begin
            region_d = REG_BOTTOM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            click_x_q <= '0;
            click_y_q <= '0;
            region_q  <= REG_NONE;
        end else if (left_press_next) begin
            click_x_q <= xpos;
            click_y_q <= ypos;
            region_q  <= region_d;
        end
    end

    assign click_x      = click_x_q;
    assign click_y      = click_y_q;
    assign click_region = region_q;

endmodule

// File: tb/tb_mouse_click_conditioner.sv
// Randomised and directed bench for mouse_click_conditioner; a run-length
// reference model feeds a scoreboard queue checked by an independent monitor.
module tb_mouse_click_conditioner;
    import vga_pkg::*;

    localparam int D = 4;

    typedef struct packed {
        logic        lh, rh, lp, lr, rp, rr;
        logic [11:0] cx, cy;
        logic [1:0]  rg;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mouse_left_raw, mouse_right_raw;
    logic [11:0] xpos, ypos;
    logic        left_held, right_held, left_press, left_release;
    logic        right_press, right_release;
    logic [11:0] click_x, click_y;
    logic [1:0]  click_region;

    int compared   = 0;
    int mismatched = 0;

    obs_t exp_q[$];

    // Reference state: raw history per button, accepted level and run length.
    bit          hist[2][$];
    bit          m_held[2];
    int          m_run[2];
    logic [11:0] m_cx, m_cy;
    logic [1:0]  m_rg;

    always #5 clk = ~clk;

    mouse_click_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .mouse_left_raw (mouse_left_raw),
        .mouse_right_raw(mouse_right_raw),
        .xpos           (xpos),
        .ypos           (ypos),
        .left_held      (left_held),
        .right_held     (right_held),
        .left_press     (left_press),
        .left_release   (left_release),
        .right_press    (right_press),
        .right_release  (right_release),
        .click_x        (click_x),
        .click_y        (click_y),
        .click_region   (click_region)
    );

    function automatic logic [1:0] ref_region(int x, int y);
        bit xin;
        xin = x >= int'(RECT_X_MIDDLE) && x <= int'(RECT_X_MIDDLE) + int'(RECT_CHAR_X);
        if (xin && y >= int'(RECT_Y) && y <= int'(RECT_Y) + int'(RECT_CHAR_Y)) return 2'd1;
        if (xin && y >= int'(RECT_Y_2) && y <= int'(RECT_Y_2) + int'(RECT_CHAR_Y)) return 2'd2;
        return 2'd0;
    endfunction

    // A level change is accepted once the synchronised input (raw two edges
    // earlier) has differed from the accepted level for D+1 consecutive edges.
    task automatic deb_step(input int b, input bit raw, output bit pr, output bit rl);
        bit s;
        s = hist[b].pop_front();
        hist[b].push_back(raw);
        pr = 1'b0;
        rl = 1'b0;
        if (s != m_held[b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == D + 1) begin
            m_held[b] = ~m_held[b];
            m_run[b]  = 0;
            pr = m_held[b];
            rl = ~m_held[b];
        end
    endtask

    task automatic model_edge(output obs_t e);
        bit lp, lr, rp, rr;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                hist[b]   = {1'b0, 1'b0};
                m_held[b] = 1'b0;
                m_run[b]  = 0;
            end
            m_cx = '0; m_cy = '0; m_rg = '0;
            lp = 0; lr = 0; rp = 0; rr = 0;
        end else begin
            deb_step(0, mouse_left_raw, lp, lr);
            deb_step(1, mouse_right_raw, rp, rr);
            if (lp) begin
                m_cx = xpos;
                m_cy = ypos;
                m_rg = ref_region(int'(xpos), int'(ypos));
            end
        end
        e = '{lh: m_held[0], rh: m_held[1], lp: lp, lr: lr, rp: rp, rr: rr,
              cx: m_cx, cy: m_cy, rg: m_rg};
    endtask

    // Called just after a negedge with inputs set: predict the next posedge, then wait it out.
    task automatic drive_cycle();
        obs_t e;
        model_edge(e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) drive_cycle();
    endtask

    task automatic check_latency(input string name, input bit want_release);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 50) begin
            drive_cycle();
            n++;
            seen = want_release ? left_release : left_press;
        end
        compared++;
        if (!seen || n != D + 3) begin
            mismatched++;
            $display("FAIL %s: pulse after %0d edges (seen=%0d), required %0d", name, n, seen, D + 3);
        end
    endtask

    function automatic logic [11:0] pick_coord(logic [11:0] lo, logic [11:0] span);
        int v;
        case ($urandom_range(0, 5))
            0: v = int'(lo) - 1;
            1: v = int'(lo);
            2: v = int'(lo) + int'(span);
            3: v = int'(lo) + int'(span) + 1;
            4: v = int'(lo) + int'($urandom_range(0, span));
            default: v = int'($urandom_range(0, 4095));
        endcase
        return 12'(v);
    endfunction

    // Monitor: every cycle the DUT presents a full output set, checked against the oldest prediction.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{lh: left_held, rh: right_held, lp: left_press, lr: left_release,
                      rp: right_press, rr: right_release, cx: click_x, cy: click_y,
                      rg: click_region};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL outputs @%0t: got held=%b%b pr=%b%b rl=%b%b x=%0d y=%0d rg=%0d, required held=%b%b pr=%b%b rl=%b%b x=%0d y=%0d rg=%0d",
                             $time, a.lh, a.rh, a.lp, a.rp, a.lr, a.rr, a.cx, a.cy, a.rg,
                             e.lh, e.rh, e.lp, e.rp, e.lr, e.rr, e.cx, e.cy, e.rg);
                end
            end
        end
    end

    initial begin
        int rem_l, rem_r, nrel, drain;
        logic [11:0] xs[3];
        logic [11:0] ys[3];
        rst = 1'b1;
        mouse_left_raw = 1'b0;
        mouse_right_raw = 1'b0;
        xpos = '0;
        ypos = '0;
        @(negedge clk);
        cyc(3);
        rst = 1'b0;
        cyc(5);

        // First press on the top button, then its release
        xpos = RECT_X_MIDDLE;
        ypos = RECT_Y;
        mouse_left_raw = 1'b1;
        check_latency("press_latency", 1'b0);
        cyc(4);
        mouse_left_raw = 1'b0;
        check_latency("release_latency", 1'b1);
        cyc(3);

        // Too-short press is rejected
        mouse_left_raw = 1'b1;
        cyc(3);
        mouse_left_raw = 1'b0;
        cyc(10);

        // Region boundaries
        xs[0] = RECT_X_MIDDLE;      ys[0] = RECT_Y_2 + RECT_CHAR_Y;
        xs[1] = RECT_X_MIDDLE;      ys[1] = RECT_Y_2 + RECT_CHAR_Y + 12'd1;
        xs[2] = RECT_X_MIDDLE - 12'd1; ys[2] = RECT_Y;
        for (int i = 0; i < 3; i++) begin
            xpos = xs[i];
            ypos = ys[i];
            mouse_left_raw = 1'b1;
            cyc(D + 6);
            mouse_left_raw = 1'b0;
            cyc(D + 6);
        end

        // Simultaneous left/right, then right alone must not touch click_*
        xpos = RECT_X_MIDDLE + RECT_CHAR_X;
        ypos = RECT_Y + 12'd5;
        mouse_left_raw = 1'b1;
        mouse_right_raw = 1'b1;
        cyc(10);
        mouse_left_raw = 1'b0;
        mouse_right_raw = 1'b0;
        cyc(10);
        xpos = 12'd7;
        mouse_right_raw = 1'b1;
        cyc(10);
        mouse_right_raw = 1'b0;
        cyc(10);

        // Reset while pressed with raw still high: needs a fresh full debounce
        mouse_left_raw = 1'b1;
        cyc(10);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_latency("press_after_reset", 1'b0);
        cyc(3);

        // Release bounce produces exactly one release
        nrel = 0;
        mouse_left_raw = 1'b0;
        for (int i = 0; i < 2; i++) begin drive_cycle(); nrel += int'(left_release); end
        mouse_left_raw = 1'b1;
        drive_cycle(); nrel += int'(left_release);
        mouse_left_raw = 1'b0;
        for (int i = 0; i < 14; i++) begin drive_cycle(); nrel += int'(left_release); end
        compared++;
        if (nrel != 1) begin
            mismatched++;
            $display("FAIL bounce_release_count: got %0d releases, required 1", nrel);
        end

        // Random phase: run lengths straddle the debounce threshold
        rem_l = 0;
        rem_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rem_l == 0) begin mouse_left_raw = ~mouse_left_raw; rem_l = $urandom_range(1, 12); end
            if (rem_r == 0) begin mouse_right_raw = ~mouse_right_raw; rem_r = $urandom_range(1, 12); end
            rem_l--;
            rem_r--;
            xpos = pick_coord(RECT_X_MIDDLE, RECT_CHAR_X);
            ypos = ($urandom_range(0, 1) == 0) ? pick_coord(RECT_Y, RECT_CHAR_Y)
                                               : pick_coord(RECT_Y_2, RECT_CHAR_Y);
            rst = ($urandom_range(0, 399) == 0);
            drive_cycle();
        end
        rst = 1'b0;
        cyc(2);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
